// File: rtl/popcount_rr_scheduler.sv
// Round-robin front end for a shared 1-cycle population counter: grants one requester per
// cycle, tags each word with its requester index and returns results in issue order via a 4-entry FIFO.
module popcount_rr_scheduler #(
    parameter int WIDTH = 16,
    parameter int REQ_N = 4,
    localparam int IDW = $clog2(REQ_N),
    localparam int CW  = $clog2(WIDTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [REQ_N*WIDTH-1:0] req_data_i,
    input  logic [REQ_N-1:0]       req_val_i,
    output logic [REQ_N-1:0]       req_ready_o,
    output logic [WIDTH-1:0]       cnt_data_o,
    output logic                   cnt_data_val_o,
    input  logic [CW-1:0]          cnt_res_i,
    input  logic                   cnt_res_val_i,
    output logic [CW-1:0]          res_data_o,
    output logic [IDW-1:0]         res_id_o,
    output logic                   res_val_o,
    input  logic                   res_ready_i,
    output logic                   err_o
);

    localparam int DEPTH = 4;

    logic [IDW-1:0]    last_grant_q;
    logic [2:0]        occ_q;
    logic [1:0]        wr_ptr_q;
    logic [1:0]        rd_ptr_q;
    logic              s1_val_q;
    logic              s2_val_q;
    logic [WIDTH-1:0]  s1_data_q;
    logic [IDW-1:0]    s1_id_q;
    logic [IDW-1:0]    s2_id_q;
    logic              err_q;
    logic              rst_d_q;
    logic [IDW+CW-1:0] mem_q [DEPTH];

    logic              credit_ok;
    logic              grant_any;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand;
    logic [REQ_N-1:0]  grant;
    logic              push;
    logic              pop;
    logic              proto_err;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % REQ_N;
        return IDW'(s);
    endfunction

    // Every issued word holds one FIFO slot until popped, so the FIFO can never overflow.
    assign credit_ok = (occ_q + 3'(s1_val_q) + 3'(s2_val_q)) < 3'd4;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant_q;
        cand      = last_grant_q;
        grant     = '0;
        for (int k = 1; k <= REQ_N; k++) begin
            cand = rr_idx(last_grant_q, k);
            if (!grant_any && req_val_i[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (srst_i || !credit_ok) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready_o    = grant;
    assign cnt_data_o     = s1_data_q;
    assign cnt_data_val_o = s1_val_q & ~srst_i;
    assign res_val_o      = (occ_q != 3'd0) & ~srst_i;
    assign err_o          = err_q & ~srst_i;
    assign {res_id_o, res_data_o} = mem_q[rd_ptr_q];

    assign push = s2_val_q & cnt_res_val_i & ~srst_i;
    assign pop  = res_val_o & res_ready_i;
    // A stale counter result may land the first cycle after reset; it is neither stored nor flagged.
    assign proto_err = ~rst_d_q & (cnt_res_val_i != s2_val_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            last_grant_q <= IDW'(REQ_N - 1);
            occ_q        <= 3'd0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            s1_val_q     <= 1'b0;
            s2_val_q     <= 1'b0;
            err_q        <= 1'b0;
            rst_d_q      <= 1'b1;
        end else begin
            rst_d_q  <= 1'b0;
            s1_val_q <= grant_any;
            s2_val_q <= s1_val_q;
            if (grant_any) begin
                last_grant_q <= grant_idx;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            if (push && !pop) begin
                occ_q <= occ_q + 3'd1;
            end else if (pop && !push) begin
                occ_q <= occ_q - 3'd1;
            end
            if (proto_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: the datapath and FIFO storage carry no reset; valids and pointers alone define contents.
    always_ff @(posedge clk_i) begin
        if (grant_any) begin
            s1_data_q <= req_data_i[grant_idx*WIDTH +: WIDTH];
            s1_id_q   <= grant_idx;
        end
        s2_id_q <= s1_id_q;
        if (push) begin
            mem_q[wr_ptr_q] <= {s2_id_q, cnt_res_i};
        end
    end

endmodule

// File: tb/tb_popcount_rr_scheduler.sv
// Bench for popcount_rr_scheduler: a 1-cycle counter responder, a transaction-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_popcount_rr_scheduler;

    localparam int WIDTH = 16;
    localparam int REQ_N = 4;
    localparam int IDW   = 2;
    localparam int CW    = 5;

    logic                   clk_i = 1'b0;
    logic                   srst_i = 1'b1;
    logic [REQ_N*WIDTH-1:0] req_data_i = '0;
    logic [REQ_N-1:0]       req_val_i = '0;
    logic [REQ_N-1:0]       req_ready_o;
    logic [WIDTH-1:0]       cnt_data_o;
    logic                   cnt_data_val_o;
    logic [CW-1:0]          cnt_res_i = '0;
    logic                   cnt_res_val_i = 1'b0;
    logic [CW-1:0]          res_data_o;
    logic [IDW-1:0]         res_id_o;
    logic                   res_val_o;
    logic                   res_ready_i = 1'b1;
    logic                   err_o;

    always #5 clk_i = ~clk_i;

    popcount_rr_scheduler #(.WIDTH(WIDTH), .REQ_N(REQ_N)) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .req_data_i     (req_data_i),
        .req_val_i      (req_val_i),
        .req_ready_o    (req_ready_o),
        .cnt_data_o     (cnt_data_o),
        .cnt_data_val_o (cnt_data_val_o),
        .cnt_res_i      (cnt_res_i),
        .cnt_res_val_i  (cnt_res_val_i),
        .res_data_o     (res_data_o),
        .res_id_o       (res_id_o),
        .res_val_o      (res_val_o),
        .res_ready_i    (res_ready_i),
        .err_o          (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shared counter: returns the popcount of the word seen in cycle n during cycle n+1.
    logic inj_req = 1'b0;
    initial begin
        logic             v;
        logic [WIDTH-1:0] d;
        forever begin
            @(negedge clk_i);
            v = (cnt_data_val_o === 1'b1);
            d = cnt_data_o;
            @(posedge clk_i);
            #2;
            cnt_res_val_i = v || inj_req;
            cnt_res_i     = CW'($countones(d));
            inj_req       = 1'b0;
        end
    end

    // Reference model: a queue of issued transactions plus a count of unreturned slots.
    typedef struct {
        int cnt;
        int id;
        int vis;
    } ent_t;

    ent_t             q[$];
    int               cyc = 0;
    bit               model_on = 1'b0;
    int               last_m;
    int               outst;
    bit               xd1, xd2, rst_d1, err_m, pend_val;
    logic [WIDTH-1:0] pend_data;

    always @(negedge clk_i) begin
        logic [REQ_N-1:0] eg;
        int               gi;
        int               idx;
        bit               exp_rv;
        if (srst_i) begin
            check("rst_ready", req_ready_o, 0);
            check("rst_cnt_val", cnt_data_val_o, 0);
            check("rst_res_val", res_val_o, 0);
            check("rst_err", err_o, 0);
            last_m   = REQ_N - 1;
            outst    = 0;
            q.delete();
            xd1      = 1'b0;
            xd2      = 1'b0;
            pend_val = 1'b0;
            err_m    = 1'b0;
            rst_d1   = 1'b1;
            model_on = 1'b1;
        end else if (model_on) begin
            eg = '0;
            gi = -1;
            if (outst < 4) begin
                for (int k = 1; k <= REQ_N; k++) begin
                    idx = (last_m + k) % REQ_N;
                    if (gi < 0 && req_val_i[idx]) gi = idx;
                end
            end
            if (gi >= 0) eg[gi] = 1'b1;
            check("m_grant", req_ready_o, eg);
            check("m_cnt_val", cnt_data_val_o, pend_val);
            if (pend_val) check("m_cnt_data", cnt_data_o, pend_data);
            exp_rv = (q.size() > 0) && (q[0].vis <= cyc);
            check("m_res_val", res_val_o, exp_rv);
            if (exp_rv) begin
                check("m_res_data", res_data_o, q[0].cnt);
                check("m_res_id", res_id_o, q[0].id);
            end
            check("m_err", err_o, err_m);
            if (!rst_d1 && (cnt_res_val_i !== xd2)) err_m = 1'b1;
            if (exp_rv && res_ready_i) begin
                void'(q.pop_front());
                outst--;
            end
            xd2      = xd1;
            xd1      = (gi >= 0);
            pend_val = (gi >= 0);
            if (gi >= 0) begin
                pend_data = req_data_i[gi*WIDTH +: WIDTH];
                q.push_back('{cnt: $countones(pend_data), id: gi, vis: cyc + 3});
                outst++;
                last_m = gi;
            end
            rst_d1 = 1'b0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        srst_i    = 1'b1;
        req_val_i = '0;
        tick();
        tick();
        srst_i = 1'b0;
    endtask

    task automatic single(input int idx, input logic [WIDTH-1:0] data, input int expcnt);
        req_data_i[idx*WIDTH +: WIDTH] = data;
        req_val_i = REQ_N'(1 << idx);
        sample();
        check("single_grant", req_ready_o, 1 << idx);
        tick();
        req_val_i = '0;
        sample();
        check("single_cnt_val", cnt_data_val_o, 1);
        check("single_cnt_data", cnt_data_o, data);
        tick();
        tick();
        sample();
        check("single_res_val", res_val_o, 1);
        check("single_res_data", res_data_o, expcnt);
        check("single_res_id", res_id_o, idx);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               n_xfer;
        logic [CW-1:0]    held_data;
        logic [IDW-1:0]   held_id;

        // Single request with literal latencies.
        do_reset();
        single(2, 16'hF0F0, 8);

        // Fairness: all valid, one grant per cycle in strict rotation.
        do_reset();
        req_data_i = {16'h8421, 16'h00FF, 16'h0003, 16'h0001};
        req_val_i  = '1;
        for (int k = 0; k < 8; k++) begin
            sample();
            check("rr_order", req_ready_o, 1 << (k % REQ_N));
            tick();
        end
        req_val_i = '0;
        repeat (6) tick();

        // Backpressure: exactly four transfers, then a stable stalled head.
        res_ready_i = 1'b0;
        req_val_i   = '1;
        n_xfer      = 0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (|(req_ready_o & req_val_i)) n_xfer++;
            tick();
        end
        check("bp_xfer_count", n_xfer, 4);
        sample();
        check("bp_stall", req_ready_o, 0);
        check("bp_res_val", res_val_o, 1);
        check("bp_head_id", res_id_o, 0);
        held_data = res_data_o;
        held_id   = res_id_o;
        tick();
        sample();
        check("bp_hold_data", res_data_o, held_data);
        check("bp_hold_id", res_id_o, held_id);
        tick();
        res_ready_i = 1'b1;
        req_val_i   = '0;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("bp_pop_val", res_val_o, 1);
            check("bp_pop_id", res_id_o, k);
            tick();
        end
        sample();
        check("bp_drained", res_val_o, 0);
        tick();
        req_val_i = '1;
        sample();
        check("bp_resume", req_ready_o, 4'b0001);
        tick();
        req_val_i = '0;
        repeat (6) tick();

        // Boundary words.
        single(1, 16'h0000, 0);
        single(3, 16'hFFFF, 16);

        // Spurious counter result with nothing in flight.
        repeat (3) tick();
        inj_req = 1'b1;
        sample();
        check("perr_not_yet", err_o, 0);
        tick();
        sample();
        check("perr_set", err_o, 1);
        check("perr_no_write", res_val_o, 0);
        tick();
        tick();
        sample();
        check("perr_sticky", err_o, 1);
        tick();
        do_reset();
        sample();
        check("perr_cleared", err_o, 0);
        tick();

        // Reset with two words in flight and two queued.
        res_ready_i = 1'b0;
        req_val_i   = '1;
        n_xfer      = 0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (|(req_ready_o & req_val_i)) n_xfer++;
            tick();
            if (n_xfer == 4) break;
        end
        check("mid_xfer_count", n_xfer, 4);
        srst_i    = 1'b1;
        req_val_i = '0;
        tick();
        srst_i      = 1'b0;
        inj_req     = 1'b1;
        res_ready_i = 1'b1;
        sample();
        check("mid_res_val", res_val_o, 0);
        check("mid_err", err_o, 0);
        tick();
        sample();
        check("mid_err_after", err_o, 0);
        check("mid_res_val_after", res_val_o, 0);
        tick();
        req_val_i = '1;
        sample();
        check("mid_first_grant", req_ready_o, 4'b0001);
        tick();
        req_val_i = '0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/popcount_rr_scheduler.md
POPCOUNT_RR_SCHEDULER -- requirements
Module: popcount_rr_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width in bits.
REQ-002 The block SHALL have parameter REQ_N, default 4, giving the requester count; legal range 2..16.
REQ-003 The block SHALL have these ports; IDW = $clog2(REQ_N), CW = $clog2(WIDTH)+1:
- clk_i  in  1  single clock, all logic on rising edge
- srst_i  in  1  synchronous reset, active-high
- req_data_i  in  REQ_N*WIDTH  requester words; requester i at bits [i*WIDTH +: WIDTH]
- req_val_i  in  REQ_N  per-requester valid
- req_ready_o  out  REQ_N  per-requester ready (grant)
- cnt_data_o  out  WIDTH  word to the shared population counter
- cnt_data_val_o  out  1  valid to the counter
- cnt_res_i  in  CW  counter result
- cnt_res_val_i  in  1  counter result valid
- res_data_o  out  CW  returned count
- res_id_o  out  IDW  requester index of res_data_o
- res_val_o  out  1  result valid
- res_ready_i  in  1  result sink ready
- err_o  out  1  sticky protocol error

Function
REQ-004 A requester transfer SHALL occur in a cycle where req_val_i[i] and req_ready_o[i] are both 1.
REQ-005 At most one bit of req_ready_o SHALL be 1 per cycle; req_ready_o MAY depend combinationally on req_val_i; requesters SHALL NOT make req_val_i depend on req_ready_o.
REQ-006 Grant SHALL be round-robin: search starts at index (last_grant+1) mod REQ_N, wraps, and picks the first index with req_val_i set.
REQ-007 last_grant SHALL update only on a transfer.
REQ-008 A grant SHALL be issued only if occ + inflight < 4, where occ = result FIFO occupancy (0..4) and inflight = issued words without a returned result (0..2); same-cycle pops are not credited.
REQ-009 A word transferred in cycle t SHALL appear on cnt_data_o with cnt_data_val_o=1 in cycle t+1 (registered); cnt_data_val_o SHALL be 0 in cycles with no transfer in t.
REQ-010 The counter is fixed at 1-cycle latency: the result for a word driven in t+1 SHALL be taken from cnt_res_i when cnt_res_val_i=1 in t+2.
REQ-011 The requester index SHALL travel with each word through a 2-stage tag pipeline aligned to REQ-009/REQ-010.
REQ-012 A returned result SHALL be written into a 4-entry FIFO at the end of t+2 and be visible on res_data_o/res_id_o with res_val_o=1 from t+3 at the earliest.
REQ-013 The FIFO SHALL pop when res_val_o and res_ready_i are both 1; results SHALL be returned in issue order.
REQ-014 Simultaneous push and pop SHALL leave occ unchanged; push into a full FIFO cannot occur by REQ-008.
REQ-015 res_data_o/res_id_o SHALL hold stable while res_val_o=1 and res_ready_i=0.
REQ-016 With res_ready_i held 1 and continuous requests, the block SHALL sustain one transfer per cycle.
REQ-017 cnt_res_val_i=1 with no tag in stage 2, or cnt_res_val_i=0 when stage 2 holds a tag, SHALL set err_o=1 until reset.
REQ-018 In the REQ-017 mismatch cases, a spurious result SHALL be dropped and a missing result SHALL retire its tag with no FIFO write.

Reset
REQ-019 While srst_i=1: req_ready_o=0, cnt_data_val_o=0, res_val_o=0, err_o=0, occ=0, inflight=0, last_grant=REQ_N-1 (requester 0 wins first).
REQ-020 Reset mid-operation SHALL discard all in-flight words and FIFO contents; a counter result arriving the cycle after reset deasserts SHALL be ignored and SHALL NOT set err_o.
REQ-021 cnt_data_o, res_data_o and res_id_o values SHALL be don't-care while their valids are 0.

Verification
REQ-022 Single request: after reset, req_val_i=4'b0100, data2=16'hF0F0, res_ready_i=1 -> req_ready_o=4'b0100 in cycle t, cnt_data_o=16'hF0F0 valid in t+1, res_data_o=8, res_id_o=2, res_val_o=1 in t+3.
REQ-023 Fairness: all four req_val_i held 1 for 8 cycles, res_ready_i=1 -> grant order 0,1,2,3,0,1,2,3, one per cycle, results in the same order.
REQ-024 Backpressure: res_ready_i=0, all requesters valid -> exactly 4 transfers, then req_ready_o=0 while res_val_o stays 1 with stable data; raise res_ready_i -> 4 results pop in issue order, then granting resumes.
REQ-025 Boundaries: data 16'h0000 -> res_data_o=0; data 16'hFFFF -> res_data_o=16 (5-bit field).
REQ-026 Protocol error: cnt_res_val_i pulsed with nothing in flight -> err_o=1 next cycle and held, no FIFO write; srst_i -> err_o=0.
REQ-027 Reset mid-stream: srst_i asserted with 2 in flight and 2 queued -> after release res_val_o=0, err_o=0, next grant goes to requester 0.
